l1_mem_arbiter: RTL and testbench
=================================

Name: l1_mem_arbiter

Overview:
- Shares the single L1-to-memory bus between two requesters: port 0 (data cache) and port 1 (instruction cache).
- Sequences each transaction:
  - Read miss: command, then an 8-beat block fill.
  - Write-through store: command, then wait for write acknowledge.
- Round-robin arbitration; routes fill beats and store completion back to the owning requester only.
- Sits between the L1 cache controllers and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data/word width.
- BEATS, 8, words per cache block (power of two).
- OFF_W, 5, byte-offset bits of a block; read addresses are aligned by zeroing these.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request pending (bit 0 = port 0).
- req_write  in  2  per-port 1 = store, 0 = block read.
- req_addr0 / req_addr1  in  ADDR_W  request address.
- req_wdata0 / req_wdata1  in  DATA_W  store data.
- req_ready  out  2  one-cycle pulse: request accepted.
- rsp_valid  out  2  fill beat valid for that port.
- rsp_data  out  DATA_W  fill beat data (shared, qualified by rsp_valid).
- rsp_last  out  1  final beat of the current fill.
- wr_done  out  2  one-cycle pulse: store acknowledged by memory.
- grant_id  out  1  port owning the bus; meaningful when busy=1.
- busy  out  1  transaction in progress.
- mem_cmd_valid  out  1  command to memory.
- mem_cmd_ready  in  1  memory accepts command.
- mem_cmd_write  out  1  1 = store, 0 = block read.
- mem_cmd_addr  out  ADDR_W  command address.
- mem_cmd_wdata  out  DATA_W  store data.
- mem_rdata_valid  in  1  fill beat present.
- mem_rdata  in  DATA_W  fill beat.
- mem_wr_ack  in  1  store completed.

Behaviour:
- All outputs registered.
- Reset state (async, immediate):
  - all outputs 0; FSM = IDLE; beat counter = 0; last-grant pointer = 1, so port 0 wins the first tie.
- FSM states: IDLE, CMD, RD_FILL, WR_WAIT.
- IDLE:
  - If any req_valid bit is set, choose the winner:
    - if only one port is requesting, that port;
    - if both are requesting, the port not equal to the last-grant pointer.
  - Latch write, address and wdata.
    - Read address is latched with bits [OFF_W-1:0] forced to 0.
    - Store address is latched unmodified.
  - Next cycle: req_ready[winner]=1 for exactly one cycle, grant_id=winner, busy=1, state=CMD.
  - No request: stay in IDLE, busy=0.
- CMD:
  - mem_cmd_valid=1 with the latched fields, held stable until sampled with mem_cmd_ready=1.
  - On that edge:
    - mem_cmd_valid drops to 0;
    - next state is RD_FILL (read) or WR_WAIT (write).
  - mem_cmd_ready sampled outside CMD is ignored.
- RD_FILL:
  - On each mem_rdata_valid:
    - rsp_valid[grant_id]=1 and rsp_data=mem_rdata on the next cycle;
    - beat counter increments.
  - Beat BEATS-1: rsp_last=1 with that beat; counter wraps to 0; pointer=grant_id; busy=0; state=IDLE.
  - Gaps between beats are allowed: rsp_valid stays 0 during gaps.
  - mem_wr_ack is ignored in this state.
- WR_WAIT:
  - On mem_wr_ack: wr_done[grant_id]=1 for one cycle; pointer=grant_id; busy=0; state=IDLE.
  - mem_rdata_valid is ignored in this state.
- Turnaround: at least one idle cycle between transactions, so back-to-back grants are spaced at least 3 cycles apart.
- Non-owner isolation: rsp_valid, wr_done and req_ready bits of the non-owner port stay 0 throughout a transaction.
- Requester obligation: hold req_valid and its fields until req_ready.
  - If req_valid drops before the grant, the request is still serviced (it is latched in IDLE).
- Arrival during busy: a request arriving mid-transaction waits; it is evaluated in IDLE.
- Fairness: with both ports continuously requesting, grants strictly alternate.
- Reset mid-transaction: abort immediately, all outputs 0, no completion pulse. Memory-side cleanup is the memory model's responsibility.
- Latency:
  - Read: req_valid to req_ready = 1 cycle.
  - Read: last memory beat to rsp_last = 1 cycle.
  - Minimum store (mem_cmd_ready and mem_wr_ack each held high): wr_done 4 cycles after req_valid.

Test Plan:
- Reset, then a port-0 read of 0x0000_1234; memory gives ready immediately and beats 0xA0..0xA7 back-to-back.
  - mem_cmd_addr=0x0000_1220, mem_cmd_write=0.
  - rsp_valid[0] for 8 cycles, data 0xA0..0xA7; rsp_last on 0xA7.
  - rsp_valid[1] never asserted.
- Port-1 store, addr 0x40, data 0xDEADBEEF; mem_cmd_ready delayed 3 cycles, mem_wr_ack 2 cycles later.
  - mem_cmd_valid held with stable fields, mem_cmd_write=1, addr 0x40 unaligned, wdata 0xDEADBEEF.
  - Single wr_done[1] pulse.
- Both ports request reads simultaneously after reset.
  - Port 0 is served first, then port 1.
  - Repeating keeps the strict alternation 0,1,0,1.
- Port-0 fill with 2-cycle gaps between beats, while port 1 requests mid-fill.
  - Port 1 gets no req_ready until a cycle after rsp_last; 8 beats are still counted correctly.
- rst_n asserted after beat 3 of a fill.
  - All outputs 0 immediately; FSM in IDLE.
  - The next request starts from beat 0 with port 0 priority.
- Spurious mem_rdata_valid and mem_wr_ack while in IDLE.
  - No rsp_valid, no wr_done, busy stays 0.

Source files
------------

// File: rtl/l1_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// l1_mem_arbiter_if
// Bundles both sides of the L1-to-memory arbiter:
//   requester side : req_valid/req_write/req_addr*/req_wdata* in,
//                    req_ready/rsp_valid/rsp_data/rsp_last/wr_done/grant_id/busy out
//   memory side    : mem_cmd_valid/write/addr/wdata out, mem_cmd_ready,
//                    mem_rdata_valid/mem_rdata/mem_wr_ack in
// Modport master is the arbiter's view; modport slave is the view of the
// environment (cache controllers plus memory model) driving it.
// ----------------------------------------------------------------------------
interface l1_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic [1:0]        wr_done;
  logic              grant_id;
  logic              busy;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_write;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_cmd_wdata;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wr_ack;

  modport master (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
           mem_cmd_ready, mem_rdata_valid, mem_rdata, mem_wr_ack,
    output req_ready, rsp_valid, rsp_data, rsp_last, wr_done, grant_id, busy,
           mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
           mem_cmd_ready, mem_rdata_valid, mem_rdata, mem_wr_ack,
    input  req_ready, rsp_valid, rsp_data, rsp_last, wr_done, grant_id, busy,
           mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// ----------------------------------------------------------------------------
// l1_mem_arbiter
// Shares one L1-to-memory bus between port 0 (data cache) and port 1
// (instruction cache). Round-robin arbitration in IDLE; each grant runs one
// transaction: a block read (command + BEATS fill beats) or a write-through
// store (command + write acknowledge). Fill beats and store completion are
// routed back only to the owning port. All outputs are registered.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - l1_mem_arbiter_if.master (requester and memory handshakes)
// ----------------------------------------------------------------------------
module l1_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 8,
  parameter int OFF_W  = 5
) (
  input logic              clk,
  input logic              rst_n,
  l1_mem_arbiter_if.master bus
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CMD     = 2'd1;
  localparam logic [1:0] RD_FILL = 2'd2;
  localparam logic [1:0] WR_WAIT = 2'd3;

  logic [1:0]        stateR;
  logic [CNT_W-1:0]  beatCntR;
  logic              lastGrantR;
  logic              winnerS;
  logic              selWriteS;
  logic [ADDR_W-1:0] selAddrS;
  logic [DATA_W-1:0] selWdataS;
  logic [ADDR_W-1:0] cmdAddrS;

  // Pick the round-robin winner and form the command fields it would launch
  always_comb begin
    winnerS   = 1'b0;
    selWriteS = 1'b0;
    selAddrS  = '0;
    selWdataS = '0;
    cmdAddrS  = '0;
    // On a tie the port that did not own the previous transaction wins
    if (bus.req_valid == 2'b11) begin
      winnerS = ~lastGrantR;
    end else begin
      winnerS = bus.req_valid[1];
    end
    if (winnerS) begin
      selWriteS = bus.req_write[1];
      selAddrS  = bus.req_addr1;
      selWdataS = bus.req_wdata1;
    end else begin
      selWriteS = bus.req_write[0];
      selAddrS  = bus.req_addr0;
      selWdataS = bus.req_wdata0;
    end
    // Block reads fetch the whole aligned block; stores keep the exact address
    if (selWriteS) begin
      cmdAddrS = selAddrS;
    end else begin
      cmdAddrS = {selAddrS[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end
  end

  // Transaction FSM and every registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR            <= IDLE;
      beatCntR          <= '0;
      lastGrantR        <= 1'b1;
      bus.req_ready     <= 2'b00;
      bus.rsp_valid     <= 2'b00;
      bus.rsp_data      <= '0;
      bus.rsp_last      <= 1'b0;
      bus.wr_done       <= 2'b00;
      bus.grant_id      <= 1'b0;
      bus.busy          <= 1'b0;
      bus.mem_cmd_valid <= 1'b0;
      bus.mem_cmd_write <= 1'b0;
      bus.mem_cmd_addr  <= '0;
      bus.mem_cmd_wdata <= '0;
    end else begin
      // Single-cycle pulses fall back to 0 unless re-asserted below
      bus.req_ready <= 2'b00;
      bus.rsp_valid <= 2'b00;
      bus.rsp_last  <= 1'b0;
      bus.wr_done   <= 2'b00;
      case (stateR)
        IDLE: begin
          if (bus.req_valid != 2'b00) begin
            stateR            <= CMD;
            bus.req_ready     <= winnerS ? 2'b10 : 2'b01;
            bus.grant_id      <= winnerS;
            bus.busy          <= 1'b1;
            bus.mem_cmd_write <= selWriteS;
            bus.mem_cmd_addr  <= cmdAddrS;
            bus.mem_cmd_wdata <= selWdataS;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        CMD: begin
          // Command goes out the cycle after acceptance and is held until taken
          if (!bus.mem_cmd_valid) begin
            bus.mem_cmd_valid <= 1'b1;
          end else if (bus.mem_cmd_ready) begin
            bus.mem_cmd_valid <= 1'b0;
            stateR            <= bus.mem_cmd_write ? WR_WAIT : RD_FILL;
          end else begin
            bus.mem_cmd_valid <= 1'b1;
          end
        end
        RD_FILL: begin
          if (bus.mem_rdata_valid) begin
            bus.rsp_valid <= bus.grant_id ? 2'b10 : 2'b01;
            bus.rsp_data  <= bus.mem_rdata;
            if (beatCntR == LAST_BEAT) begin
              beatCntR     <= '0;
              bus.rsp_last <= 1'b1;
              lastGrantR   <= bus.grant_id;
              bus.busy     <= 1'b0;
              stateR       <= IDLE;
            end else begin
              beatCntR <= beatCntR + CNT_W'(1);
            end
          end else begin
            beatCntR <= beatCntR;
          end
        end
        WR_WAIT: begin
          if (bus.mem_wr_ack) begin
            bus.wr_done <= bus.grant_id ? 2'b10 : 2'b01;
            lastGrantR  <= bus.grant_id;
            bus.busy    <= 1'b0;
            stateR      <= IDLE;
          end else begin
            stateR <= WR_WAIT;
          end
        end
        default: begin
          stateR   <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_l1_mem_arbiter
// Directed bench for l1_mem_arbiter: drives requesters and a scripted memory
// through the interface and compares outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_l1_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checkCnt = 0;
  int   errCnt   = 0;

  l1_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .OFF_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [10:0] ctlS;
  assign ctlS = {bus.req_ready, bus.rsp_valid, bus.rsp_last, bus.wr_done,
                 bus.grant_id, bus.busy, bus.mem_cmd_valid, bus.mem_cmd_write};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.req_valid       = 2'b00;
    bus.req_write       = 2'b00;
    bus.req_addr0       = 32'h0;
    bus.req_addr1       = 32'h0;
    bus.req_wdata0      = 32'h0;
    bus.req_wdata1      = 32'h0;
    bus.mem_cmd_ready   = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = 32'h0;
    bus.mem_wr_ack      = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_ctl"}, 64'(ctlS), 64'h0);
    check({tag, "_dat"}, {bus.rsp_data, bus.mem_cmd_addr}, 64'h0);
    check({tag, "_wd"}, 64'(bus.mem_cmd_wdata), 64'h0);
  endtask

  task automatic applyReset(input string tag);
    clearInputs();
    rst_n = 1'b0;
    #1;
    checkAllZero(tag);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a req_ready pulse and check it went to expPort only
  task automatic waitGrant(input string tag, input int expPort, output int cyc);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cyc++;
      if (bus.req_ready != 2'b00) break;
    end
    check({tag, "_rdy"}, 64'(bus.req_ready), 64'(2'b01 << expPort));
    check({tag, "_gid"}, 64'(bus.grant_id), 64'(expPort));
    check({tag, "_busy"}, 64'(bus.busy), 64'h1);
  endtask

  // Wait for the command, check fields, stall it 'delay' cycles, then accept
  task automatic serveCmd(input string tag, input logic expWrite, input logic [31:0] expAddr,
                          input logic [31:0] expWdata, input int delay);
    bus.mem_cmd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_cmd_valid) break;
      tick();
    end
    check({tag, "_cv"}, 64'(bus.mem_cmd_valid), 64'h1);
    check({tag, "_cw"}, 64'(bus.mem_cmd_write), 64'(expWrite));
    check({tag, "_ca"}, 64'(bus.mem_cmd_addr), 64'(expAddr));
    check({tag, "_cd"}, 64'(bus.mem_cmd_wdata), 64'(expWdata));
    for (int d = 0; d < delay; d++) begin
      tick();
      check({tag, "_hold_v"}, 64'(bus.mem_cmd_valid), 64'h1);
      check({tag, "_hold_a"}, 64'(bus.mem_cmd_addr), 64'(expAddr));
      check({tag, "_hold_d"}, 64'(bus.mem_cmd_wdata), 64'(expWdata));
    end
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    check({tag, "_cdrop"}, 64'(bus.mem_cmd_valid), 64'h0);
  endtask

  // Deliver beats first..lastExcl-1 with 'gap' idle cycles after each
  task automatic readFill(input string tag, input int port, input logic [31:0] base,
                          input int gap, input int first, input int lastExcl);
    for (int i = first; i < lastExcl; i++) begin
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = base + 32'(i);
      tick();
      bus.mem_rdata_valid = 1'b0;
      check({tag, "_rv"}, 64'(bus.rsp_valid), 64'(2'b01 << port));
      check({tag, "_rd"}, 64'(bus.rsp_data), 64'(base + 32'(i)));
      check({tag, "_rl"}, 64'(bus.rsp_last), 64'(i == BEATS - 1));
      check({tag, "_nordy"}, 64'(bus.req_ready), 64'h0);
      if (i == BEATS - 1) begin
        check({tag, "_idle"}, 64'(bus.busy), 64'h0);
      end else begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check({tag, "_gap_rv"}, 64'(bus.rsp_valid), 64'h0);
          check({tag, "_gap_rdy"}, 64'(bus.req_ready), 64'h0);
        end
      end
    end
  endtask

  initial begin
    int cyc;
    clearInputs();

    // 1: port-0 read of 0x1234, immediate command ready, back-to-back beats
    applyReset("rst1");
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr0 = 32'h0000_1234;
    waitGrant("t1", 0, cyc);
    check("t1_lat", 64'(cyc), 64'd1);
    bus.req_valid = 2'b00;
    serveCmd("t1", 1'b0, 32'h0000_1220, 32'h0, 0);
    readFill("t1", 0, 32'hA0, 0, 0, BEATS);

    // 2: port-1 store, command ready after 3 cycles, ack 2 cycles later
    bus.req_valid  = 2'b10;
    bus.req_write  = 2'b10;
    bus.req_addr1  = 32'h0000_0040;
    bus.req_wdata1 = 32'hDEAD_BEEF;
    waitGrant("t2", 1, cyc);
    bus.req_valid = 2'b00;
    serveCmd("t2", 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 3);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t2_wait_wd", 64'(bus.wr_done), 64'h0);
      check("t2_wait_busy", 64'(bus.busy), 64'h1);
    end
    bus.mem_wr_ack = 1'b1;
    tick();
    bus.mem_wr_ack = 1'b0;
    check("t2_wd", 64'(bus.wr_done), 64'(2'b10));
    check("t2_idle", 64'(bus.busy), 64'h0);
    tick();
    check("t2_wd_pulse", 64'(bus.wr_done), 64'h0);

    // 3: both ports requesting reads continuously -> 0,1,0,1
    applyReset("rst3");
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr0 = 32'h0000_0100;
    bus.req_addr1 = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      waitGrant("t3", k % 2, cyc);
      serveCmd("t3", 1'b0, (k % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100, 32'h0, 0);
      readFill("t3", k % 2, 32'h1000 * 32'(k + 1), 0, 0, BEATS);
    end
    bus.req_valid = 2'b00;

    // 4: gapped port-0 fill, port 1 arrives mid-fill and must wait
    bus.req_valid = 2'b01;
    bus.req_addr0 = 32'h0000_3004;
    waitGrant("t4", 0, cyc);
    bus.req_valid = 2'b00;
    serveCmd("t4", 1'b0, 32'h0000_3000, 32'h0, 0);
    readFill("t4", 0, 32'hC0, 2, 0, 3);
    bus.req_valid = 2'b10;
    bus.req_addr1 = 32'h0000_4444;
    readFill("t4", 0, 32'hC0, 2, 3, BEATS);
    waitGrant("t4p1", 1, cyc);
    check("t4p1_lat", 64'(cyc), 64'd1);
    bus.req_valid = 2'b00;
    serveCmd("t4p1", 1'b0, 32'h0000_4440, 32'h0, 0);
    readFill("t4p1", 1, 32'hD0, 0, 0, BEATS);

    // 5: port 0 read, then port-1 fill aborted by reset after beat 3
    bus.req_valid = 2'b01;
    bus.req_addr0 = 32'h0000_5000;
    waitGrant("t5a", 0, cyc);
    bus.req_valid = 2'b00;
    serveCmd("t5a", 1'b0, 32'h0000_5000, 32'h0, 0);
    readFill("t5a", 0, 32'h50, 0, 0, BEATS);
    bus.req_valid = 2'b10;
    bus.req_addr1 = 32'h0000_6000;
    waitGrant("t5b", 1, cyc);
    bus.req_valid = 2'b00;
    serveCmd("t5b", 1'b0, 32'h0000_6000, 32'h0, 0);
    readFill("t5b", 1, 32'hE0, 0, 0, 4);
    #2;
    applyReset("t5rst");
    bus.req_valid = 2'b11;
    bus.req_addr0 = 32'h0000_7000;
    bus.req_addr1 = 32'h0000_8000;
    waitGrant("t5c", 0, cyc);
    bus.req_valid = 2'b00;
    serveCmd("t5c", 1'b0, 32'h0000_7000, 32'h0, 0);
    readFill("t5c", 0, 32'hF0, 0, 0, BEATS);

    // 6: spurious memory responses while idle
    bus.mem_rdata_valid = 1'b1;
    bus.mem_wr_ack      = 1'b1;
    bus.mem_cmd_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_rv", 64'(bus.rsp_valid), 64'h0);
      check("t6_wd", 64'(bus.wr_done), 64'h0);
      check("t6_busy", 64'(bus.busy), 64'h0);
    end

    // 7: minimum store with ready and ack held high -> wr_done 4 cycles later
    bus.mem_rdata_valid = 1'b0;
    bus.req_valid  = 2'b01;
    bus.req_write  = 2'b01;
    bus.req_addr0  = 32'h0000_1234;
    bus.req_wdata0 = 32'h1234_5678;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        check("t7_rdy", 64'(bus.req_ready), 64'(2'b01));
        bus.req_valid = 2'b00;
      end
      if (bus.mem_cmd_valid) begin
        check("t7_addr", 64'(bus.mem_cmd_addr), 64'h0000_1234);
        check("t7_data", 64'(bus.mem_cmd_wdata), 64'h1234_5678);
      end
      if (bus.wr_done != 2'b00) break;
    end
    check("t7_lat", 64'(cyc), 64'd4);
    check("t7_wd", 64'(bus.wr_done), 64'(2'b01));
    bus.mem_wr_ack    = 1'b0;
    bus.mem_cmd_ready = 1'b0;
    tick();
    check("t7_wd_pulse", 64'(bus.wr_done), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
